// File: rtl/io_input_port.sv
// io_input_port: input-side memory-mapped peripheral for the board button and switches.
// Synchronises and debounces the raw pins, latches a sticky button-press flag that is
// cleared by a processor read, counts presses, and returns read data combinationally.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   button_raw   raw button pin (asynchronous to clk)
//   sw_raw       raw switch pins (asynchronous to clk)
//   a            processor byte address
//   re           processor read strobe, qualifies clear-on-read
//   rd           read data for a (combinational)
//   hit          a selects this peripheral (combinational)
//   button_level debounced logical button level, 1 = pressed
//   sw_level     debounced switch levels
module io_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SW_WIDTH        = 8,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                button_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic [31:0]         a,
    input  logic                re,
    output logic [31:0]         rd,
    output logic                hit,
    output logic                button_level,
    output logic [SW_WIDTH-1:0] sw_level
);

    // Button occupies the top bit of the combined input vector.
    localparam int unsigned N     = SW_WIDTH + 1;
    localparam int unsigned BTN   = SW_WIDTH;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] ADDR_BTN = 32'hC000_0004;
    localparam logic [31:0] ADDR_SW  = 32'hC000_0008;
    localparam logic [31:0] ADDR_CNT = 32'hC000_000C;

    logic [N-1:0]     raw_vec;
    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     stable;
    logic [CNT_W-1:0] cnt [N];
    logic             pressed;
    logic [7:0]       press_cnt;
    logic             press_c;
    logic             clear_c;

    // Polarity-correct the button so every downstream bit is logical (1 = active).
    assign raw_vec = {button_raw ^ BTN_ACTIVE_LOW, sw_raw};

    // A press is the edge where the button debouncer commits a 0 -> 1 transition.
    always_comb begin
        press_c = (sync2[BTN] != stable[BTN]) && (cnt[BTN] == CNT_MAX) && sync2[BTN];
        clear_c = re && (a == ADDR_BTN);
    end

    // Two-flop synchronisers and per-input debounce counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
            for (int i = 0; i < int'(N); i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky press flag (set beats clear-on-read) and wrapping press counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pressed   <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            if (press_c) begin
                pressed   <= 1'b1;
                press_cnt <= press_cnt + 8'd1;
            end else if (clear_c) begin
                pressed <= 1'b0;
            end
        end
    end

    assign button_level = stable[BTN];
    assign sw_level     = stable[SW_WIDTH-1:0];

    // Combinational read map; rd reflects pressed before any clearing edge.
    always_comb begin
        rd  = 32'd0;
        hit = 1'b0;
        case (a)
            ADDR_BTN: begin
                hit = 1'b1;
                rd  = {30'd0, stable[BTN], pressed};
            end
            ADDR_SW: begin
                hit = 1'b1;
                rd  = 32'(stable[SW_WIDTH-1:0]);
            end
            ADDR_CNT: begin
                hit = 1'b1;
                rd  = {24'd0, press_cnt};
            end
            default: begin
                rd  = 32'd0;
                hit = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed self-checking bench for io_input_port with a
// small debounce window. Expected values are queued when stimulus is applied
// and popped when the DUT output is sampled.
module tb_io_input_port;

    localparam int unsigned DEB = 4;
    localparam int unsigned SWW = 8;

    localparam logic [31:0] A_BTN = 32'hC000_0004;
    localparam logic [31:0] A_SW  = 32'hC000_0008;
    localparam logic [31:0] A_CNT = 32'hC000_000C;
    localparam logic [31:0] A_BAD = 32'h0000_0010;

    logic           clk;
    logic           reset;
    logic           button_raw;
    logic [SWW-1:0] sw_raw;
    logic [31:0]    a;
    logic           re;
    logic [31:0]    rd;
    logic           hit;
    logic           button_level;
    logic [SWW-1:0] sw_level;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;
    int   exp_cnt;

    io_input_port #(
        .DEBOUNCE_CYCLES(DEB),
        .SW_WIDTH       (SWW),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (button_raw),
        .sw_raw      (sw_raw),
        .a           (a),
        .re          (re),
        .rd          (rd),
        .hit         (hit),
        .button_level(button_level),
        .sw_level    (sw_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the sampled output.
    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive an address with re low and check rd after it settles.
    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        push_exp(tag, exp);
        #1;
        pop_check(rd);
    endtask

    task automatic lvl_check(input string tag, input logic exp);
        push_exp(tag, 32'(exp));
        pop_check(32'(button_level));
    endtask

    // One clean press and release, each held long enough to be debounced.
    task automatic do_press();
        button_raw = 1'b0;
        repeat (DEB + 2) tick();
        button_raw = 1'b1;
        repeat (DEB + 2) tick();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_cnt    = 0;
        reset      = 1'b1;
        button_raw = 1'b1;
        sw_raw     = '0;
        a          = 32'd0;
        re         = 1'b0;
        repeat (3) tick();

        // Reset state.
        rd_check("rst_btn", A_BTN, 32'd0);
        rd_check("rst_cnt", A_CNT, 32'd0);
        lvl_check("rst_level", 1'b0);

        // Switch latency: 0xA5 applied at release, visible exactly on edge 6.
        reset  = 1'b0;
        sw_raw = 8'hA5;
        for (int k = 0; k <= 6; k++) begin
            rd_check($sformatf("sw_lat_%0d", k), A_SW, (k == 6) ? 32'h0000_00A5 : 32'd0);
            if (k < 6) tick();
        end
        a = A_SW;
        push_exp("sw_hit", 32'd1);
        #1;
        pop_check(32'(hit));
        rd_check("btn_after_rst", A_BTN, 32'd0);
        rd_check("cnt_after_rst", A_CNT, 32'd0);

        // Clean press held 10 cycles; level rises on edge 6.
        button_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            lvl_check($sformatf("press_lvl_e%0d", k), (k >= 6) ? 1'b1 : 1'b0);
        end
        exp_cnt = 1;
        rd_check("press_btn", A_BTN, 32'h3);
        rd_check("press_cnt", A_CNT, 32'(exp_cnt));

        // Clear-on-read while held: the clearing read still sees pressed.
        a  = A_BTN;
        re = 1'b1;
        push_exp("clr_read", 32'h3);
        #1;
        pop_check(rd);
        tick();
        re = 1'b0;
        rd_check("clr_after", A_BTN, 32'h2);
        button_raw = 1'b1;
        repeat (5) tick();
        rd_check("clr_release_e5", A_BTN, 32'h2);
        tick();
        rd_check("clr_release_e6", A_BTN, 32'h0);

        // 3-cycle glitch is rejected.
        button_raw = 1'b0;
        repeat (3) tick();
        button_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            lvl_check($sformatf("glitch_lvl_%0d", k), 1'b0);
            tick();
        end
        rd_check("glitch_btn", A_BTN, 32'h0);
        rd_check("glitch_cnt", A_CNT, 32'(exp_cnt));

        // Clear-read on the very edge a new press commits: set wins.
        button_raw = 1'b0;
        repeat (5) tick();
        a  = A_BTN;
        re = 1'b1;
        push_exp("coincide_pre", 32'h0);
        #1;
        pop_check(rd);
        tick();
        re = 1'b0;
        exp_cnt++;
        rd_check("coincide_btn", A_BTN, 32'h3);
        rd_check("coincide_cnt", A_CNT, 32'(exp_cnt));
        button_raw = 1'b1;
        repeat (DEB + 2) tick();

        // Reset, then 256 presses wrap the counter back to 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        rd_check("wrap_start", A_CNT, 32'd0);
        for (int p = 0; p < 256; p++) begin
            do_press();
            exp_cnt = (exp_cnt + 1) % 256;
            if (p == 0 || p == 254) rd_check($sformatf("wrap_cnt_%0d", p + 1), A_CNT, 32'(exp_cnt));
        end
        rd_check("wrap_cnt_256", A_CNT, 32'd0);
        rd_check("wrap_btn", A_BTN, 32'h1);

        // Unmapped address: no hit, zero data, and re there does not clear.
        a  = A_BAD;
        re = 1'b1;
        push_exp("bad_rd", 32'd0);
        #1;
        pop_check(rd);
        push_exp("bad_hit", 32'd0);
        pop_check(32'(hit));
        tick();
        re = 1'b0;
        rd_check("bad_no_clear", A_BTN, 32'h1);

        // Reset mid-count with button held: re-detected as a new press.
        button_raw = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_check("midrst_btn", A_BTN, 32'h0);
        rd_check("midrst_cnt", A_CNT, 32'd0);
        repeat (5) tick();
        lvl_check("midrst_lvl_e5", 1'b0);
        tick();
        lvl_check("midrst_lvl_e6", 1'b1);
        rd_check("midrst_press_btn", A_BTN, 32'h3);
        rd_check("midrst_press_cnt", A_CNT, 32'd1);
        rd_check("midrst_sw", A_SW, 32'h0000_00A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Input-side peripheral of the memory-mapped I/O map, owning addresses 0xC000_0004 (button) and 0xC000_0008 (switches), plus 0xC000_000C (press counter).
- Synchronises and debounces the raw board button and switches.
- Latches a sticky button-press event that the processor clears by reading it.
- Returns read data combinationally, with a hit flag the data-memory mux uses to select it over RAM.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 2 or more.
- SW_WIDTH, 8, number of slide switches.
- BTN_ACTIVE_LOW, 1, 1 means the raw button pin reads 0 when pressed.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- button_raw  input  1  raw board button pin, asynchronous to clk
- sw_raw  input  SW_WIDTH  raw switch pins, asynchronous to clk
- a  input  32  processor byte address
- re  input  1  processor read strobe; qualifies clear-on-read
- rd  output  32  read data for a, combinational
- hit  output  1  1 when a is 0xC000_0004, 0xC000_0008 or 0xC000_000C
- button_level  output  1  debounced logical button level (1 = pressed)
- sw_level  output  SW_WIDTH  debounced switch levels

Behaviour:
- Clock and reset
  - One clock domain, clk.
  - Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Synchroniser
  - Each raw input passes through a 2-flop synchroniser.
  - The button is polarity-corrected (inverted when BTN_ACTIVE_LOW=1) before the first flop.
  - Reset loads logical 0 (released / off) into both flops.
- Debouncer (one counter per input, SW_WIDTH+1 counters, each wide enough for DEBOUNCE_CYCLES-1)
  - When synced == stable: counter <= 0.
  - When synced != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - When synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and never changes stable.
  - Latency from a raw change to stable changing is 2 + DEBOUNCE_CYCLES rising edges.
  - button_level and sw_level are the stable registers.
- Press event: a press is the cycle in which button stable goes 0 to 1.
  - On a press, pressed <= 1 and press_cnt (8 bits) increments.
  - press_cnt wraps from 255 to 0.
  - Release (1 to 0) changes neither pressed nor press_cnt.
- Clear-on-read
  - At a rising edge with re=1 and a==0xC000_0004, pressed <= 0.
  - If a press occurs in the same cycle, set wins and pressed stays 1.
  - Reads of the other addresses, or re=0, have no side effects.
  - press_cnt is never cleared by reads.
- Read map (combinational on a; rd is valid regardless of re)
  - 0xC000_0004: {30'b0, button_level, pressed}
  - 0xC000_0008: {(32-SW_WIDTH)'b0, sw_level}
  - 0xC000_000C: {24'b0, press_cnt}
  - Any other address: rd = 0, hit = 0.
  - rd shows pressed from before the clearing edge, so the read that clears the flag still returns 1.
- Reset values: rd depends only on a, and with all state zero it reads 0 everywhere.
  - pressed, press_cnt, all counters, stable registers and sync flops = 0.
  - Hence button_level=0 and sw_level=0.
- Reset mid-operation
  - A count in progress is discarded.
  - A held button is re-detected as a new press after 2 + DEBOUNCE_CYCLES cycles, and counted.
  - Reset takes priority over set and clear.
- Bench value: DEBOUNCE_CYCLES=4.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1):
- Reset, then read 0xC000_0004, 0xC000_0008 and 0xC000_000C with sw_raw=0xA5 applied at reset release -> rd=0 for 0x04 and 0x0C; 0x08 reads 0xA5 exactly 6 edges after release and 0 before.
- button_raw low for 10 cycles -> button_level rises on edge 6; 0xC000_0004 reads 0x3; 0xC000_000C reads 1.
- button_raw low for 3 cycles, then high -> button_level stays 0; pressed=0; press_cnt unchanged.
- Pressed=1, then assert re with a=0xC000_0004 for one cycle -> rd=0x3 during that cycle; next cycle rd=0x2 while still held, 0x0 after release is debounced.
- Clear-read coincides with a new debounced press edge -> pressed remains 1; press_cnt increments.
- 256 clean presses from press_cnt=0 -> press_cnt reads 0 (wrap); pressed=1.
- Address 0x0000_0010 -> hit=0, rd=0; re there does not clear pressed.
